// File: rtl/inv_pkg.sv
// Shared constants and types for the round-robin inverter scheduler.
package inv_pkg;
  localparam int DEFAULT_NUM_REQ = 4;
  localparam int DEFAULT_WIDTH   = 8;
  localparam int COUNT_W         = 16;

  typedef logic [$clog2(DEFAULT_NUM_REQ)-1:0] req_idx_t;

  function automatic int wrap_inc(input int i, input int n);
    return (i == n - 1) ? 0 : i + 1;
  endfunction
endpackage

// File: rtl/inv_cell.sv
// Single-bit inverter cell.
module inv_cell (
  input  logic a,
  output logic y
);
  assign y = ~a;
endmodule

// File: rtl/rr_arbiter.sv
// Round-robin winner select: first valid index at or above ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);
  always_comb begin
    int j;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(ptr) + k) % NUM_REQ;
      if (!any && valid[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = IDX_W'(j);
      end
    end
  end
endmodule

// File: rtl/inv_sched.sv
// Shares one inverter datapath among NUM_REQ requesters, round-robin,
// with a single registered result slot that supports 1 result per cycle.
module inv_sched
  import inv_pkg::*;
#(
  parameter int NUM_REQ = DEFAULT_NUM_REQ,
  parameter int WIDTH   = DEFAULT_WIDTH,
  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            cfg_enable,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ-1:0][WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic                            resp_valid,
  output logic [WIDTH-1:0]                resp_data,
  output logic [IDX_W-1:0]                resp_id,
  input  logic                            resp_ready,
  output logic [COUNT_W-1:0]              done_count
);
  logic [IDX_W-1:0]   rr_ptr;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   win_idx;
  logic               win_any;
  logic               accept;
  logic               drain;
  logic [WIDTH-1:0]   sel_data;
  logic [WIDTH-1:0]   inv_data;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (win_idx),
    .any   (win_any)
  );

  // The slot is free when empty or being drained this cycle.
  assign accept    = !rst && cfg_enable && (!resp_valid || resp_ready) && win_any;
  assign req_ready = accept ? grant : '0;
  assign drain     = resp_valid && resp_ready;
  assign sel_data  = req_data[win_idx];

  inv_cell u_inv [WIDTH-1:0] (
    .a (sel_data),
    .y (inv_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_id    <= '0;
      rr_ptr     <= '0;
    end else if (accept) begin
      resp_valid <= 1'b1;
      resp_data  <= inv_data;
      resp_id    <= win_idx;
      rr_ptr     <= IDX_W'(wrap_inc(int'(win_idx), NUM_REQ));
    end else if (drain) begin
      resp_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      done_count <= '0;
    else if (drain && done_count != {COUNT_W{1'b1}})
      done_count <= done_count + 1'b1;
  end
endmodule

// File: tb/tb_inv_sched.sv
// Randomized and directed bench for inv_sched against a cycle-level model.
module tb_inv_sched;
  localparam int N = 4;
  localparam int W = 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 cfg_enable;
  logic [N-1:0]         req_valid;
  logic [N-1:0][W-1:0]  req_data;
  logic [N-1:0]         req_ready;
  logic                 resp_valid;
  logic [W-1:0]         resp_data;
  logic [1:0]           resp_id;
  logic                 resp_ready;
  logic [15:0]          done_count;

  int n_chk = 0;
  int n_fail = 0;

  // model state
  bit       m_valid;
  bit [7:0] m_data;
  int       m_id;
  int       m_ptr;
  int       m_cnt;
  logic [N-1:0] obs_ready;

  inv_sched #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_enable (cfg_enable),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_id    (resp_id),
    .resp_ready (resp_ready),
    .done_count (done_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_data = 0; m_id = 0; m_ptr = 0; m_cnt = 0;
  endtask

  // One clock: check outputs at negedge, advance model at posedge.
  task automatic cycle(input bit do_chk);
    logic [N-1:0] er;
    int win;
    bit drained;
    @(negedge clk);
    er = '0;
    win = -1;
    if (!rst && cfg_enable && (!m_valid || resp_ready))
      for (int k = 0; k < N; k++)
        if (win < 0 && req_valid[(m_ptr + k) % N]) win = (m_ptr + k) % N;
    if (win >= 0) er[win] = 1'b1;
    obs_ready = req_ready;
    if (do_chk) begin
      chk("req_ready",  32'(req_ready),  32'(er));
      chk("resp_valid", 32'(resp_valid), 32'(m_valid));
      chk("resp_data",  32'(resp_data),  32'(m_data));
      chk("resp_id",    32'(resp_id),    32'(m_id));
      chk("done_count", 32'(done_count), 32'(m_cnt));
    end
    @(posedge clk);
    drained = m_valid && resp_ready;
    if (drained && m_cnt != 16'hFFFF) m_cnt++;
    if (win >= 0) begin
      m_valid = 1;
      m_data  = ~req_data[win];
      m_id    = win;
      m_ptr   = (win + 1) % N;
    end else if (drained) begin
      m_valid = 0;
    end
    #1;
  endtask

  initial begin
    int guard;
    rst = 1'b1; cfg_enable = 1'b1; req_valid = '1; resp_ready = 1'b1;
    for (int i = 0; i < N; i++) req_data[i] = 8'(8'h10 * i + 3);
    model_reset();
    #12;
    // reset state with requests pending
    chk("rst_req_ready",  32'(req_ready),  0);
    chk("rst_resp_valid", 32'(resp_valid), 0);
    chk("rst_done_count", 32'(done_count), 0);
    @(posedge clk); #1 rst = 1'b0;

    // backpressure: requesters 1 and 3, ptr at 0
    req_valid = 4'b1010; resp_ready = 1'b0;
    req_data[1] = 8'h3C; req_data[3] = 8'hF0;
    cycle(1);
    chk("bp_first_grant", 32'(obs_ready), 32'(4'b0010));
    for (int i = 0; i < 5; i++) begin
      cycle(1);
      chk("bp_hold_ready", 32'(obs_ready), 0);
      chk("bp_hold_id",    32'(resp_id),   1);
      chk("bp_hold_data",  32'(resp_data), 32'(8'hC3));
    end
    resp_ready = 1'b1;
    cycle(1);
    req_valid = '0;
    cycle(1);
    chk("bp_next_id",   32'(resp_id),   3);
    chk("bp_next_data", 32'(resp_data), 32'(8'h0F));

    // single request
    req_valid = 4'b0100; req_data[2] = 8'hA5;
    cycle(1);
    chk("single_ready", 32'(obs_ready), 32'(4'b0100));
    req_valid = '0;
    chk("single_valid", 32'(resp_valid), 1);
    chk("single_data",  32'(resp_data),  32'(8'h5A));
    chk("single_id",    32'(resp_id),    2);
    cycle(1);

    // async reset mid-response
    req_valid = 4'b0001; resp_ready = 1'b0;
    cycle(1);
    #2 rst = 1'b1;
    #1;
    chk("arst_resp_valid", 32'(resp_valid), 0);
    chk("arst_req_ready",  32'(req_ready),  0);
    chk("arst_done_count", 32'(done_count), 0);
    model_reset();
    @(posedge clk); #1 rst = 1'b0;
    req_valid = '0; resp_ready = 1'b1;
    cycle(1);

    // fairness from ptr 0
    req_valid = '1;
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < N; i++) req_data[i] = 8'($urandom);
      cycle(1);
      chk("fair_grant", 32'(obs_ready), 32'(1 << (k % N)));
      chk("fair_valid", 32'(resp_valid), 1);
    end

    // enable gating, then resume from held pointer
    cfg_enable = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cycle(1);
      chk("en_gate_ready", 32'(obs_ready), 0);
    end
    chk("en_gate_valid", 32'(resp_valid), 0);
    cfg_enable = 1'b1;
    cycle(1);
    chk("en_resume", 32'(obs_ready), 32'(4'b0001));

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      cfg_enable = ($urandom_range(0, 7) != 0);
      req_valid  = N'($urandom);
      resp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) req_data[i] = 8'($urandom);
      cycle(1);
    end

    // saturation of done_count
    cfg_enable = 1'b1; req_valid = '1; resp_ready = 1'b1;
    guard = 0;
    while (m_cnt != 16'hFFFF && guard < 70000) begin
      cycle(0);
      guard++;
    end
    chk("sat_reached", 32'(m_cnt), 32'(16'hFFFF));
    for (int k = 0; k < 3; k++) cycle(1);
    chk("sat_hold", 32'(done_count), 32'(16'hFFFF));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
